mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles mem_req is held without mem_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request strobe; sampled only in IDLE.
REQ-005 opcode  input  7  instruction opcode; LOAD=7'b0000011, STORE=7'b0100011.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  effective byte address from ALU.
REQ-008 store_data  input  32  rs2 value, right-aligned.
REQ-009 busy  output  1  high from the cycle after accepted start until done.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 load_data  output  32  extended load result, held until next done.
REQ-012 err  output  1  valid with done: misaligned access or timeout.
REQ-013 mem_req  output  1  memory request, held until mem_ack or timeout.
REQ-014 mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-015 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-016 mem_wdata  output  32  store data replicated into byte lanes.
REQ-017 mem_be  output  4  byte enables; 4'b0000 for reads.
REQ-018 mem_ack  input  1  memory response; one-cycle pulse; read data valid with it.
REQ-019 mem_rdata  input  32  read word.

Function
REQ-020 States: IDLE, REQ, DONE; IDLE->REQ on start with LOAD/STORE, IDLE->DONE on start with any other opcode, REQ->DONE on mem_ack or timeout, DONE->IDLE unconditionally.
REQ-021 Request fields (mem_we, mem_addr, mem_wdata, mem_be, funct3, addr[1:0]) registered at start acceptance; stable throughout REQ.
REQ-022 mem_req high exactly in REQ; first asserted the cycle after start.
REQ-023 Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}; SH be=4'b0011<<addr[1:0], wdata={2{sd[15:0]}}; SW be=4'b1111, wdata=sd.
REQ-024 Load extract: byte/half selected by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged; load_data registered on mem_ack cycle.
REQ-025 done pulses in DONE; ack in cycle k gives done in cycle k+1; minimum start-to-done latency 2 cycles.
REQ-026 Non-LOAD/STORE opcode: no mem_req, done after 1 cycle, load_data=0, err=0.
REQ-027 Store completion leaves load_data at 0.
REQ-028 Timeout counter resets on REQ entry; if mem_ack absent for TIMEOUT cycles, leave REQ, err=1, load_data=0.
REQ-029 mem_ack in IDLE or DONE ignored; start while busy ignored.
REQ-030 mem_ack on the final timeout cycle counts as success (ack wins).

Reset
REQ-031 On rst, asynchronously: state=IDLE, busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, load_data=0, timeout counter=0.
REQ-032 rst during REQ drops mem_req immediately; no done generated for the aborted access.

Configuration
REQ-033 Macro MISALIGN_CHECK_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 skips REQ, done next cycle, err=1, load_data=0.
REQ-034 Macro MISALIGN_CHECK_EN undefined: no check; H uses addr[1] only, W ignores addr[1:0]; err reports only timeout.

Verification
REQ-035 SB addr=0x1003 sd=0x000000AB, ack after 2 cycles -> be=4'b1000, wdata=0xABABABAB, mem_addr=0x1000, done 1 cycle after ack, err=0.
REQ-036 LB addr=0x2001 rdata=0x12348056 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x2002 -> 0x00001234.
REQ-037 LW, mem_ack never asserted, TIMEOUT=16 -> mem_req high 16 cycles, then done=1, err=1, load_data=0.
REQ-038 LW addr=0x3002: with MISALIGN_CHECK_EN -> no mem_req, done after 1 cycle, err=1; without -> mem_addr=0x3000, err=0.
REQ-039 opcode=7'b0110011 start -> no mem_req, done after 1 cycle, load_data=0.
REQ-040 rst asserted mid-REQ -> mem_req low same cycle, no done; new LW after reset completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: drives one word-aligned memory request per LOAD/STORE and
// returns the extended load result. `define MISALIGN_CHECK_EN to reject misaligned H/W accesses.
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam int         CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;

   logic          is_mem, misalign, go_req;
   logic [1:0]    half_off;
   logic [3:0]    be_st;
   logic [31:0]   wd_st;
   logic [31:0]   shifted;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   ext;

   assign is_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
`ifdef MISALIGN_CHECK_EN
   assign misalign = is_mem && (((funct3[1:0] == 2'b01) && addr[0]) ||
                                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
`else
   assign misalign = 1'b0;
`endif
   assign go_req   = is_mem && !misalign;
   // Halfwords only ever land on lane 0 or 2; addr[0] is ignored.
   assign half_off = {addr[1], 1'b0};

   always_comb begin
      be_st = 4'b1111;
      wd_st = store_data;
      case (funct3[1:0])
         2'b00: begin
            be_st = 4'b0001 << addr[1:0];
            wd_st = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_st = 4'b0011 << half_off;
            wd_st = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   assign shifted  = mem_rdata >> {off_q, 3'b000};
   assign byte_sel = shifted[7:0];
   assign half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      case (f3_q)
         3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  ext = {24'h0, byte_sel};
         3'b101:  ext = {16'h0, half_sel};
         default: ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start) state_n = go_req ? REQ : DONE;
         REQ:  if (mem_ack || (cnt == LAST)) state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign mem_req = (state == REQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         f3_q      <= '0;
         off_q     <= '0;
         cnt       <= '0;
         err       <= 1'b0;
         load_data <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               mem_we    <= (opcode == OP_STORE);
               mem_addr  <= {addr[31:2], 2'b00};
               mem_wdata <= wd_st;
               mem_be    <= ((opcode == OP_STORE) && go_req) ? be_st : 4'b0000;
               f3_q      <= funct3;
               off_q     <= addr[1:0];
               cnt       <= '0;
               if (!go_req) begin
                  err       <= misalign;
                  load_data <= '0;
               end
            end
            REQ: begin
               // An ack on the last allowed cycle still counts as success.
               if (mem_ack) begin
                  err       <= 1'b0;
                  load_data <= mem_we ? 32'h0 : ext;
               end else if (cnt == LAST) begin
                  err       <= 1'b1;
                  load_data <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: err <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit: table of accesses plus reset/busy corner sequences.
module tb_mem_access_unit;

   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;
   localparam logic [6:0] RT = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        busy, done, err, mem_req, mem_we;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   mem_access_unit #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
      .addr(addr), .store_data(store_data), .busy(busy), .done(done),
      .load_data(load_data), .err(err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      logic [31:0] rdata;
      int          dly;     // REQ-cycle index of the ack, -1 = never
      int          e_nreq;  // expected number of mem_req cycles
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_addr;
      logic [31:0] e_load;
      logic        e_err;
      int          e_lat;   // start cycle to done cycle
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int  cyc, nreq;
      logic got, first;
      @(negedge clk);
      start = 1'b1; opcode = v.op; funct3 = v.f3; addr = v.a; store_data = v.sd;
      mem_rdata = v.rdata;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; nreq = 0; got = 1'b0; first = 1'b1;
      while (cyc < 100 && !got) begin
         if (mem_req) begin
            if (first) begin
               first = 1'b0;
               chk({v.name, " we"},   32'(mem_we), 32'(v.e_we));
               chk({v.name, " be"},   32'(mem_be), 32'(v.e_be));
               chk({v.name, " addr"}, mem_addr, v.e_addr);
               if (v.e_we) chk({v.name, " wdata"}, mem_wdata, v.e_wdata);
            end
            if (nreq == v.dly) mem_ack = 1'b1;
            nreq++;
         end
         if (done) got = 1'b1;
         else begin
            @(negedge clk);
            mem_ack = 1'b0;
            cyc++;
         end
      end
      mem_ack = 1'b0;
      chk({v.name, " done_seen"}, 32'(got), 32'd1);
      chk({v.name, " latency"},   cyc, v.e_lat);
      chk({v.name, " nreq"},      nreq, v.e_nreq);
      chk({v.name, " err"},       32'(err), 32'(v.e_err));
      chk({v.name, " load"},      load_data, v.e_load);
      @(negedge clk);
      chk({v.name, " done_pulse"}, 32'(done), 32'd0);
      chk({v.name, " load_hold"},  load_data, v.e_load);
   endtask

   initial begin
      int seen;
      rst = 1'b1; start = 1'b0; opcode = '0; funct3 = '0; addr = '0;
      store_data = '0; mem_ack = 1'b0; mem_rdata = '0;

      //      name        op  f3     addr          sd            rdata         dly nreq we be       wdata         maddr         load          err lat
      vecs.push_back('{"LB",    LD, 3'b000, 32'h0000_2001, 32'h0,        32'h1234_8056, 0, 1, 0, 4'b0000, 32'h0,        32'h0000_2000, 32'hFFFF_FF80, 0, 2});
      vecs.push_back('{"LBU",   LD, 3'b100, 32'h0000_2001, 32'h0,        32'h1234_8056, 0, 1, 0, 4'b0000, 32'h0,        32'h0000_2000, 32'h0000_0080, 0, 2});
      vecs.push_back('{"LHU",   LD, 3'b101, 32'h0000_2002, 32'h0,        32'h1234_8056, 1, 2, 0, 4'b0000, 32'h0,        32'h0000_2000, 32'h0000_1234, 0, 3});
      vecs.push_back('{"LH",    LD, 3'b001, 32'h0000_2000, 32'h0,        32'h1234_8056, 0, 1, 0, 4'b0000, 32'h0,        32'h0000_2000, 32'hFFFF_8056, 0, 2});
      vecs.push_back('{"LB3",   LD, 3'b000, 32'h0000_2003, 32'h0,        32'h7F00_0000, 0, 1, 0, 4'b0000, 32'h0,        32'h0000_2000, 32'h0000_007F, 0, 2});
      vecs.push_back('{"LW",    LD, 3'b010, 32'h0000_2000, 32'h0,        32'hDEAD_BEEF, 1, 2, 0, 4'b0000, 32'h0,        32'h0000_2000, 32'hDEAD_BEEF, 0, 3});
      vecs.push_back('{"SB",    ST, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        2, 3, 1, 4'b1000, 32'hABAB_ABAB, 32'h0000_1000, 32'h0,        0, 4});
      vecs.push_back('{"SH",    ST, 3'b001, 32'h0000_1002, 32'h0000_CAFE, 32'h0,        0, 1, 1, 4'b1100, 32'hCAFE_CAFE, 32'h0000_1000, 32'h0,        0, 2});
      vecs.push_back('{"SW",    ST, 3'b010, 32'h0000_1004, 32'h1234_5678, 32'h0,        0, 1, 1, 4'b1111, 32'h1234_5678, 32'h0000_1004, 32'h0,        0, 2});
      vecs.push_back('{"LW2",   LD, 3'b010, 32'h0000_2000, 32'h0,        32'hA5A5_0001, 0, 1, 0, 4'b0000, 32'h0,        32'h0000_2000, 32'hA5A5_0001, 0, 2});
      vecs.push_back('{"RTYPE", RT, 3'b000, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,         32'h0,        0, 1});
`ifdef MISALIGN_CHECK_EN
      vecs.push_back('{"LWmis", LD, 3'b010, 32'h0000_3002, 32'h0,        32'h55AA_55AA, 0, 0, 0, 4'b0000, 32'h0,        32'h0,         32'h0,        1, 1});
`else
      vecs.push_back('{"LWmis", LD, 3'b010, 32'h0000_3002, 32'h0,        32'h55AA_55AA, 0, 1, 0, 4'b0000, 32'h0,        32'h0000_3000, 32'h55AA_55AA, 0, 2});
`endif
      vecs.push_back('{"LWlast", LD, 3'b010, 32'h0000_2000, 32'h0,       32'h0BAD_F00D, 15, 16, 0, 4'b0000, 32'h0,      32'h0000_2000, 32'h0BAD_F00D, 0, 17});
      vecs.push_back('{"LWtmo", LD, 3'b010, 32'h0000_2000, 32'h0,        32'h1111_1111, -1, 16, 0, 4'b0000, 32'h0,      32'h0000_2000, 32'h0,        1, 17});

      repeat (2) @(negedge clk);
      chk("rst busy",   32'(busy), 32'd0);
      chk("rst done",   32'(done), 32'd0);
      chk("rst err",    32'(err), 32'd0);
      chk("rst req",    32'(mem_req), 32'd0);
      chk("rst be",     32'(mem_be), 32'd0);
      chk("rst addr",   mem_addr, 32'd0);
      chk("rst wdata",  mem_wdata, 32'd0);
      chk("rst load",   load_data, 32'd0);
      rst = 1'b0;

      // ack while idle is ignored
      @(negedge clk); mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      chk("idle ack busy", 32'(busy), 32'd0);
      chk("idle ack done", 32'(done), 32'd0);

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // start pulse while busy must not spawn a second access
      @(negedge clk); start = 1'b1; opcode = LD; funct3 = 3'b010; addr = 32'h5000;
      @(negedge clk); opcode = RT;
      chk("busy req", 32'(mem_req), 32'd1);
      @(negedge clk); start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_BABE;
      @(negedge clk); mem_ack = 1'b0;
      chk("busy done",  32'(done), 32'd1);
      chk("busy load",  load_data, 32'hCAFE_BABE);
      seen = 0;
      repeat (4) begin @(negedge clk); if (done || busy) seen++; end
      chk("busy no_extra", seen, 0);

      // reset in the middle of a request
      @(negedge clk); start = 1'b1; opcode = LD; funct3 = 3'b010; addr = 32'h4000;
      @(negedge clk); start = 1'b0;
      chk("abort req_on", 32'(mem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort req_off", 32'(mem_req), 32'd0);
      chk("abort busy",    32'(busy), 32'd0);
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (20) begin @(negedge clk); if (done) seen++; end
      chk("abort no_done", seen, 0);
      run_vec('{"postrst", LD, 3'b010, 32'h0000_4000, 32'h0, 32'h1357_9BDF, 0, 1, 0, 4'b0000, 32'h0, 32'h0000_4000, 32'h1357_9BDF, 0, 2});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
